// File: rtl/shiftreg_capture.sv
// shiftreg_capture: edge-triggered capture of shift-register words with timestamps
// into a first-word-fall-through FIFO drained over a valid/ready stream.
module shiftreg_capture #(
    parameter int WIDTH   = 24,
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 16,
    parameter int OVF_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset_ni,
    input  logic                         clear_i,
    input  logic                         trigger_i,
    input  logic [WIDTH-1:0]             dout_parallel_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [WIDTH-1:0]             m_data_o,
    output logic [STAMP_W-1:0]           m_stamp_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic [OVF_W-1:0]             ovf_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    logic [WIDTH-1:0]   mem_data_q [DEPTH];
    logic [STAMP_W-1:0] mem_stamp_q [DEPTH];

    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic               trig_q, trig_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      count_q, count_d;
    logic               full_q, full_d, valid_q, valid_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d;
    logic [STAMP_W-1:0] head_stamp_q, head_stamp_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic               cap, pop, push, drop;

    always_comb begin
        stamp_d  = stamp_q + STAMP_W'(1);
        trig_d   = trigger_i;
        cap      = trigger_i & ~trig_q;
        pop      = valid_q & m_ready_i & ~clear_i;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push     = cap & ~clear_i & ((count_q != FULL_LVL) | pop);
        drop     = cap & ~clear_i & (count_q == FULL_LVL) & ~pop;
        wr_ptr_d = clear_i ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = clear_i ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = clear_i ? '0 :
                   (push & ~pop) ? count_q + LW'(1) :
                   (pop & ~push) ? count_q - LW'(1) : count_q;
        full_d   = count_d == FULL_LVL;
        valid_d  = count_d != '0;
        ovf_d    = clear_i ? '0 : (drop && ovf_q != OVF_MAX) ? ovf_q + OVF_W'(1) : ovf_q;
        head_data_d  = head_data_q;
        head_stamp_d = head_stamp_q;
        if (clear_i) begin
            head_data_d  = '0;
            head_stamp_d = '0;
        end else if (count_q == '0 || (count_q == LW'(1) && pop)) begin
            // FIFO drains to empty this cycle: new word bypasses memory, else hold last popped
            if (push) begin
                head_data_d  = dout_parallel_i;
                head_stamp_d = stamp_q;
            end
        end else begin
            head_data_d  = mem_data_q[rd_ptr_d];
            head_stamp_d = mem_stamp_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q]  <= dout_parallel_i;
            mem_stamp_q[wr_ptr_q] <= stamp_q;
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            stamp_q      <= '0;
            trig_q       <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            valid_q      <= 1'b0;
            head_data_q  <= '0;
            head_stamp_q <= '0;
            ovf_q        <= '0;
        end else begin
            stamp_q      <= stamp_d;
            trig_q       <= trig_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            valid_q      <= valid_d;
            head_data_q  <= head_data_d;
            head_stamp_q <= head_stamp_d;
            ovf_q        <= ovf_d;
        end
    end

    assign m_valid_o = valid_q;
    assign m_data_o  = head_data_q;
    assign m_stamp_o = head_stamp_q;
    assign level_o   = count_q;
    assign full_o    = full_q;
    assign ovf_cnt_o = ovf_q;
endmodule

// File: doc/shiftreg_capture.md
Name: shiftreg_capture

Overview:
- Downstream consumer of the serial-in/parallel-out shift register inside top_system.
- On each rising edge of the shift register's trigger, captures the parallel output word and a 16-bit cycle timestamp into a first-word-fall-through FIFO.
- Drains captured words over a valid/ready stream to a checker or analyzer-side consumer.
- Counts words lost to overflow.

Parameters:
- WIDTH, 24: parallel word width; matches the shift register's dout_parallel.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- STAMP_W, 16: timestamp counter width.
- OVF_W, 8: overflow counter width.

Ports:
- clk  input  1  system clock
- reset_ni  input  1  asynchronous active-low reset
- clear_i  input  1  synchronous clear: flush FIFO, zero overflow count
- trigger_i  input  1  word-complete strobe from the shift register (level; edge-detected here)
- dout_parallel_i  input  WIDTH  parallel word from the shift register
- m_valid_o  output  1  head entry available
- m_ready_i  input  1  consumer accepts head entry
- m_data_o  output  WIDTH  head entry word
- m_stamp_o  output  STAMP_W  head entry timestamp
- level_o  output  $clog2(DEPTH+1)  current occupancy
- full_o  output  1  level_o == DEPTH
- ovf_cnt_o  output  OVF_W  saturating count of dropped captures

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; m_valid_o=0, m_data_o=0, m_stamp_o=0, level_o=0, full_o=0, ovf_cnt_o=0.
  - Timestamp counter=0.
  - trig_q (registered trigger_i) resets to 1, so a trigger held high through reset produces no capture until it has been seen low.
- Timestamp: free-running, +1 every cycle out of reset, wraps 2^STAMP_W-1 -> 0. Not affected by clear_i.
- Edge detect: cap = trigger_i & ~trig_q, evaluated at each clk edge. trig_q <= trigger_i every cycle, including during clear.
- Push on cap:
  - The entry written is {dout_parallel_i, stamp} as sampled at that same edge; no extra pipeline stage.
  - Latency: if the FIFO was empty, m_valid_o=1 and m_data_o/m_stamp_o show the new entry in the cycle after the capturing edge.
- Pop: occurs at an edge where m_valid_o & m_ready_i. Outputs are FWFT; the head is stable while m_valid_o=1 and m_ready_i=0.
- m_data_o/m_stamp_o when empty: hold the last popped values; 0 after reset or clear.
- Simultaneous push+pop:
  - Not full: level unchanged, both take effect.
  - Full: push accepted because the pop frees the slot; no overflow.
  - Empty with push: no pop possible (m_valid_o=0); level becomes 1.
- Overflow: cap while full with no pop in that cycle drops the word. ovf_cnt_o increments, saturating at 2^OVF_W-1. FIFO contents are unchanged.
- clear_i has priority over push and pop in its cycle:
  - FIFO emptied, ovf_cnt_o=0.
  - A cap in the same cycle is discarded and not counted.
  - m_valid_o=0 next cycle.
- Pointers: log2(DEPTH)-bit read/write pointers wrap naturally. Occupancy is tracked by a separate counter 0..DEPTH; full_o and level_o are registered from it.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost and not counted as overflow.

Test Plan:
- Basic capture: reset, trigger_i low 3 cycles, dout_parallel_i=24'hA5C3F0, pulse trigger_i 1 cycle, m_ready_i=0 -> next cycle m_valid_o=1, m_data_o=24'hA5C3F0, m_stamp_o = stamp at capture edge, level_o=1; hold 5 cycles, values stable.
- Level vs edge: trigger_i held high 10 cycles with the word changing every cycle -> exactly one entry, holding the first-cycle word. trigger_i high through reset release -> zero entries until the next low->high.
- Fill and overflow: DEPTH=8, m_ready_i=0, 11 trigger edges with words 1..11 -> full_o=1, level_o=8, ovf_cnt_o=3; drain yields words 1..8 in order with increasing stamps.
- Full push+pop: FIFO full, m_ready_i=1 in the same cycle as a trigger edge with word 24'h00BEEF -> level_o stays 8, ovf_cnt_o unchanged, 24'h00BEEF is the last entry drained.
- Saturation and clear: OVF_W=8, 300 drops -> ovf_cnt_o=255. Then clear_i asserted in the same cycle as a trigger edge -> level_o=0, m_valid_o=0, ovf_cnt_o=0, no entry captured.
- Timestamp wrap and async reset: run past 65535 cycles, capture across the wrap -> stamps 16'hFFFF then 16'h0000 in order. Assert reset_ni low mid-drain with level_o=5 -> all outputs 0 without waiting for a clock edge.
